// File: rtl/sm4_pkg.sv
// Shared state encoding, port identifiers and default core latency for the
// SM4 arbiter controller.
package sm4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } sm4_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int CORE_LAT_DEFAULT = 66;

endpackage

// File: rtl/sm4_rr_arb2.sv
// Combinational two-way round-robin grant; prio names the port that wins a tie.
module sm4_rr_arb2
  import sm4_pkg::*;
(
  input  logic valid_a,
  input  logic valid_b,
  input  logic prio,
  output logic grant_a,
  output logic grant_b,
  output logic owner
);

  // grant the lone requester, or the prio port when both request
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    owner   = PORT_A;
    if (valid_a && (!valid_b || (prio == PORT_A))) begin
      grant_a = 1'b1;
      owner   = PORT_A;
    end else if (valid_b) begin
      grant_b = 1'b1;
      owner   = PORT_B;
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      owner   = PORT_A;
    end
  end

endmodule

// File: rtl/sm4_arbiter_ctrl.sv
// Shares one SM4 core between two requesters: round-robin grant, fixed-latency
// run timing with a timeout, and per-port result return.
module sm4_arbiter_ctrl
  import sm4_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int CORE_LAT = CORE_LAT_DEFAULT,
  parameter int TIMEOUT  = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic             a_req_mode,
  input  logic [WIDTH-1:0] a_req_key,
  input  logic [WIDTH-1:0] a_req_data,
  output logic             a_resp_valid,
  input  logic             a_resp_ready,
  output logic [WIDTH-1:0] a_resp_data,
  output logic             a_resp_err,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic             b_req_mode,
  input  logic [WIDTH-1:0] b_req_key,
  input  logic [WIDTH-1:0] b_req_data,
  output logic             b_resp_valid,
  input  logic             b_resp_ready,
  output logic [WIDTH-1:0] b_resp_data,
  output logic             b_resp_err,
  output logic             core_start,
  output logic             core_mode,
  output logic [WIDTH-1:0] core_mk,
  output logic [WIDTH-1:0] core_x,
  input  logic [WIDTH-1:0] core_y,
  input  logic             core_finish,
  output logic             busy
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAT_LAST = CW'(CORE_LAT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  sm4_state_e    state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic          prio_r, owner_r;
  logic          grant_a_s, grant_b_s, owner_s;
  logic          accept_s, done_ok_s, done_to_s, resp_hs_s;

  sm4_rr_arb2 u_arb (
    .valid_a (a_req_valid),
    .valid_b (b_req_valid),
    .prio    (prio_r),
    .grant_a (grant_a_s),
    .grant_b (grant_b_s),
    .owner   (owner_s)
  );

  // request acceptance, run completion and response handshake decode
  always_comb begin
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    accept_s    = 1'b0;
    done_ok_s   = 1'b0;
    done_to_s   = 1'b0;
    if (reset && (state_r == IDLE)) begin
      a_req_ready = grant_a_s;
      b_req_ready = grant_b_s;
      accept_s    = grant_a_s | grant_b_s;
    end else begin
      a_req_ready = 1'b0;
      b_req_ready = 1'b0;
      accept_s    = 1'b0;
    end
    // finish is sticky, so it only counts at the exact latency point
    if (state_r == RUN) begin
      done_ok_s = (cnt_r == LAT_LAST) && core_finish;
      done_to_s = !done_ok_s && (cnt_r == TO_LAST);
    end else begin
      done_ok_s = 1'b0;
      done_to_s = 1'b0;
    end
    resp_hs_s = (a_resp_valid && a_resp_ready) || (b_resp_valid && b_resp_ready);
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = START; else state_s = IDLE;
      START:   state_s = RUN;
      RUN:     if (done_ok_s || done_to_s) state_s = RESP; else state_s = RUN;
      RESP:    if (resp_hs_s) state_s = IDLE; else state_s = RESP;
      default: state_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // job latch, run counter, response registers and round-robin priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r        <= '0;
      prio_r       <= PORT_A;
      owner_r      <= PORT_A;
      core_start   <= 1'b1;
      core_mode    <= 1'b0;
      core_mk      <= '0;
      core_x       <= '0;
      busy         <= 1'b0;
      a_resp_valid <= 1'b0;
      a_resp_data  <= '0;
      a_resp_err   <= 1'b0;
      b_resp_valid <= 1'b0;
      b_resp_data  <= '0;
      b_resp_err   <= 1'b0;
    end else begin
      core_start <= (state_s == START);
      busy       <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            owner_r   <= owner_s;
            core_mode <= grant_b_s ? b_req_mode : a_req_mode;
            core_mk   <= grant_b_s ? b_req_key  : a_req_key;
            core_x    <= grant_b_s ? b_req_data : a_req_data;
          end
        end
        START: cnt_r <= '0;
        RUN: begin
          if (cnt_r != TO_LAST) cnt_r <= cnt_r + CW'(1);
          if (done_ok_s || done_to_s) begin
            if (owner_r == PORT_A) begin
              a_resp_valid <= 1'b1;
              a_resp_data  <= done_ok_s ? core_y : '0;
              a_resp_err   <= done_to_s;
            end else begin
              b_resp_valid <= 1'b1;
              b_resp_data  <= done_ok_s ? core_y : '0;
              b_resp_err   <= done_to_s;
            end
          end
        end
        RESP: begin
          if (resp_hs_s) begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            prio_r       <= ~owner_r;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_arbiter_ctrl.sv
// Scoreboard bench for sm4_arbiter_ctrl with a behavioural SM4 core stand-in.
module tb_sm4_arbiter_ctrl;

  localparam int W   = 128;
  localparam int LAT = 66;
  localparam int TO  = 127;
  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_req_valid = 1'b0, a_req_mode = 1'b0, a_resp_ready = 1'b1;
  logic b_req_valid = 1'b0, b_req_mode = 1'b0, b_resp_ready = 1'b1;
  logic [W-1:0] a_req_key = '0, a_req_data = '0, b_req_key = '0, b_req_data = '0;
  logic a_req_ready, a_resp_valid, a_resp_err, b_req_ready, b_resp_valid, b_resp_err;
  logic [W-1:0] a_resp_data, b_resp_data, core_mk, core_x, core_y;
  logic core_start, core_mode, core_finish, busy;

  int checks = 0;
  int errors = 0;
  logic stuck = 1'b0;
  logic rnd_bp = 1'b0;
  logic a_got = 1'b0, b_got = 1'b0, a_rv_seen = 1'b0;
  logic [6:0] ccnt = 7'd0;
  logic cfin = 1'b0;
  logic prio_m = 1'b0;

  typedef struct packed {
    logic         port;
    logic [127:0] data;
    logic         err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sm4_arbiter_ctrl #(.WIDTH(W), .CORE_LAT(LAT), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_mode(a_req_mode),
    .a_req_key(a_req_key), .a_req_data(a_req_data), .a_resp_valid(a_resp_valid),
    .a_resp_ready(a_resp_ready), .a_resp_data(a_resp_data), .a_resp_err(a_resp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_mode(b_req_mode),
    .b_req_key(b_req_key), .b_req_data(b_req_data), .b_resp_valid(b_resp_valid),
    .b_resp_ready(b_resp_ready), .b_resp_data(b_resp_data), .b_resp_err(b_resp_err),
    .core_start(core_start), .core_mode(core_mode), .core_mk(core_mk), .core_x(core_x),
    .core_y(core_y), .core_finish(core_finish), .busy(busy)
  );

  // Cipher stand-in: the known SM4 vector pair, otherwise an invertible mix.
  function automatic logic [127:0] core_f(logic mode, logic [127:0] k, logic [127:0] x);
    if (k == KEY && mode && x == KEY) return CT;
    if (k == KEY && !mode && x == CT) return KEY;
    if (mode) return (x ^ k) + 128'd1;
    return (x - 128'd1) ^ k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core model: result valid 50 cycles after start, finish sticky forever.
  always @(posedge clk) begin
    if (core_start) ccnt <= 7'd0;
    else if (ccnt != 7'd127) ccnt <= ccnt + 7'd1;
    if (!core_start && ccnt == 7'd50) cfin <= 1'b1;
  end
  assign core_finish = cfin & ~stuck;
  assign core_y = (ccnt >= 7'd50) ? core_f(core_mode, core_mk, core_x)
                                  : 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(logic port, logic [127:0] d, logic e);
    exp_t x;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp: port %0d data %h, expected no response", port, d);
    end else begin
      x = sb_q.pop_front();
      chk("resp_port", {127'd0, port}, {127'd0, x.port});
      chk("resp_data", d, x.data);
      chk("resp_err", {127'd0, e}, {127'd0, x.err});
    end
  endtask

  // Monitor: every response handshake is matched against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (a_resp_valid && a_resp_ready) pop_cmp(1'b0, a_resp_data, a_resp_err);
    if (b_resp_valid && b_resp_ready) pop_cmp(1'b1, b_resp_data, b_resp_err);
  end

  // Reference: round-robin order and the expected result of each job.
  task automatic expect_job(logic port, logic mode, logic [127:0] k, logic [127:0] x);
    exp_t e;
    e.port = port;
    e.data = stuck ? 128'd0 : core_f(mode, k, x);
    e.err  = stuck;
    sb_q.push_back(e);
    prio_m = ~port;
  endtask

  task automatic step();
    @(negedge clk);
    a_got = a_req_valid && a_req_ready;
    b_got = b_req_valid && b_req_ready;
    a_rv_seen = a_resp_valid;
    @(posedge clk);
    #1;
    if (a_got) a_req_valid = 1'b0;
    if (b_got) b_req_valid = 1'b0;
    if (rnd_bp) begin
      a_resp_ready = 1'($urandom_range(0, 1));
      b_resp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((a_req_valid || b_req_valid || sb_q.size() != 0) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic issue(logic ae, logic be, logic am, logic [127:0] ak, logic [127:0] ad,
                       logic bm, logic [127:0] bk, logic [127:0] bd);
    if (ae && be) begin
      if (prio_m == 1'b0) begin
        expect_job(1'b0, am, ak, ad);
        expect_job(1'b1, bm, bk, bd);
      end else begin
        expect_job(1'b1, bm, bk, bd);
        expect_job(1'b0, am, ak, ad);
      end
    end else if (ae) expect_job(1'b0, am, ak, ad);
    else if (be) expect_job(1'b1, bm, bk, bd);
    a_req_mode = am; a_req_key = ak; a_req_data = ad; a_req_valid = ae;
    b_req_mode = bm; b_req_key = bk; b_req_data = bd; b_req_valid = be;
    drain();
  endtask

  task automatic wait_accept_a();
    int n = 0;
    a_got = 1'b0;
    while (!a_got && n < 50) begin
      step();
      n++;
    end
    if (!a_got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: a_req_ready stayed 0, expected 1");
    end
  endtask

  task automatic timed_a(logic m, logic [127:0] k, logic [127:0] d, int exp_lat, string name);
    int lat = 0;
    expect_job(1'b0, m, k, d);
    a_req_mode = m; a_req_key = k; a_req_data = d; a_req_valid = 1'b1;
    wait_accept_a();
    chk("busy_after_accept", {127'd0, busy}, 128'd1);
    a_rv_seen = 1'b0;
    while (!a_rv_seen && lat < 300) begin
      step();
      lat++;
    end
    chk(name, 128'(lat), 128'(exp_lat));
    drain();
  endtask

  initial begin
    logic [127:0] d0;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d0;
    logic ae, be;
    a_req_valid = 1'b1;
    b_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_core_start", {127'd0, core_start}, 128'd1);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_a_req_ready", {127'd0, a_req_ready}, 128'd0);
    chk("rst_b_req_ready", {127'd0, b_req_ready}, 128'd0);
    chk("rst_a_resp_valid", {127'd0, a_resp_valid}, 128'd0);
    chk("rst_b_resp_valid", {127'd0, b_resp_valid}, 128'd0);
    chk("rst_a_resp_data", a_resp_data, 128'd0);
    chk("rst_b_resp_err", {127'd0, b_resp_err}, 128'd0);
    chk("rst_core_mode", {127'd0, core_mode}, 128'd0);
    chk("rst_core_mk", core_mk, 128'd0);
    chk("rst_core_x", core_x, 128'd0);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("core_start_release", {127'd0, core_start}, 128'd0);

    // contention right after reset: A first, then B
    issue(1'b1, 1'b1, 1'b1, KEY, KEY, 1'b0, KEY, CT);
    timed_a(1'b1, KEY, KEY, LAT + 2, "enc_latency");
    // A was last owner, so B wins this tie
    issue(1'b1, 1'b1, 1'b1, rnd128(), rnd128(), 1'b1, rnd128(), rnd128());
    timed_a(1'b0, KEY, CT, LAT + 2, "dec_latency");

    // backpressure on A while B waits
    a_resp_ready = 1'b0;
    expect_job(1'b0, 1'b1, KEY, KEY);
    a_req_mode = 1'b1; a_req_key = KEY; a_req_data = KEY; a_req_valid = 1'b1;
    wait_accept_a();
    a_rv_seen = 1'b0;
    for (int i = 0; i < 300 && !a_rv_seen; i++) step();
    b_req_mode = 1'b1; b_req_key = rnd128(); b_req_data = rnd128(); b_req_valid = 1'b1;
    expect_job(1'b1, b_req_mode, b_req_key, b_req_data);
    d0 = a_resp_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_a_resp_valid", {127'd0, a_resp_valid}, 128'd1);
      chk("bp_a_resp_data", a_resp_data, d0);
      chk("bp_b_req_ready", {127'd0, b_req_ready}, 128'd0);
    end
    a_resp_ready = 1'b1;
    drain();

    // stuck finish -> timeout, then a normal job
    stuck = 1'b1;
    timed_a(1'b1, rnd128(), rnd128(), TO + 2, "timeout_latency");
    stuck = 1'b0;
    timed_a(1'b1, rnd128(), rnd128(), LAT + 2, "post_timeout_latency");

    // reset during RUN drops the job
    a_req_mode = 1'b1; a_req_key = rnd128(); a_req_data = rnd128(); a_req_valid = 1'b1;
    wait_accept_a();
    repeat (21) step();
    reset = 1'b0;
    #1;
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    chk("midrst_core_start", {127'd0, core_start}, 128'd1);
    chk("midrst_a_resp_valid", {127'd0, a_resp_valid}, 128'd0);
    prio_m = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("midrst_release_start", {127'd0, core_start}, 128'd0);
    timed_a(1'b0, KEY, CT, LAT + 2, "post_reset_latency");

    // randomized traffic with random response backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ae = 1'($urandom_range(0, 1));
      be = 1'($urandom_range(0, 1));
      if (!ae && !be) ae = 1'b1;
      issue(ae, be, 1'($urandom_range(0, 1)), rnd128(), rnd128(),
            1'($urandom_range(0, 1)), rnd128(), rnd128());
    end
    rnd_bp = 1'b0;
    a_resp_ready = 1'b1;
    b_resp_ready = 1'b1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
